// File: rtl/dfr_pkg.sv
// Shared definitions for the delay-feedback reservoir blocks.
// Provides the default fixed-point format, the accumulator-width helper,
// the signed saturating rescale used on accumulator outputs, and Q16.16
// constants for +1.0 / -1.0.
package dfr_pkg;

  localparam int DFR_DATA_WIDTH = 32;
  localparam int DFR_FRAC_BITS  = 16;

  // Working width for saturate(); wide enough for any accumulator built
  // from DATA_WIDTH <= 48 and a few hundred virtual nodes.
  localparam int SAT_WIDTH = 128;

  localparam logic [31:0] ONE     = 32'h0001_0000;
  localparam logic [31:0] NEG_ONE = 32'hFFFF_0000;

  // Full-precision products summed over vn nodes never overflow this width.
  function automatic int acc_width(input int dw, input int vn);
    return 2 * dw + $clog2(vn);
  endfunction

  // Drop frac fractional bits (arithmetic shift, i.e. floor) and clamp to
  // the signed dw-bit range. The caller truncates the result to dw bits.
  function automatic logic signed [SAT_WIDTH-1:0] saturate(
    input logic signed [SAT_WIDTH-1:0] acc,
    input int                          frac,
    input int                          dw
  );
    logic signed [SAT_WIDTH-1:0] shifted;
    logic signed [SAT_WIDTH-1:0] max_v;
    logic signed [SAT_WIDTH-1:0] min_v;
    shifted = acc >>> frac;
    max_v   = (SAT_WIDTH'(1) << (dw - 1)) - SAT_WIDTH'(1);
    min_v   = -max_v - SAT_WIDTH'(1);
    if (shifted > max_v)      return max_v;
    else if (shifted < min_v) return min_v;
    return shifted;
  endfunction

endpackage

// File: rtl/dfr_mac.sv
// Two-stage multiply/accumulate for the readout layer.
//  Stage 1: registers the full-width signed product din_i * weight_i along
//           with the first/last flags of the node it belongs to.
//  Stage 2: first node loads the accumulator, later nodes add to it;
//           done_o pulses for one cycle after the last node is added.
// Ports:
//  clk, rst           clock, synchronous active-high reset
//  valid_i            din_i/weight_i are a valid node sample
//  first_i, last_i    sample is node 0 / node VN-1 of the frame
//  din_i, weight_i    signed operands, DW bits
//  acc_o              frame accumulator, ACC_W bits, signed
//  done_o             acc_o holds a complete frame sum (one cycle)
module dfr_mac #(
  parameter int DW    = 32,
  parameter int ACC_W = 68
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 first_i,
  input  logic                 last_i,
  input  logic signed [DW-1:0] din_i,
  input  logic signed [DW-1:0] weight_i,
  output logic [ACC_W-1:0]     acc_o,
  output logic                 done_o
);

  logic                   valid1_q;
  logic                   first1_q;
  logic                   last1_q;
  logic signed [2*DW-1:0] prod_q;
  logic signed [2*DW-1:0] prod_d;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic                   done_q;

  // Operands are sign-extended first so the product is exact at 2*DW bits.
  assign prod_d = (2*DW)'(din_i) * (2*DW)'(weight_i);

  // NOTE: combinational blocks assign every output a default first so no
  // path through the block leaves a value held, which would infer a latch.
  always_comb begin
    acc_d = acc_q;
    if (valid1_q) begin
      acc_d = first1_q ? ACC_W'(prod_q) : acc_q + ACC_W'(prod_q);
    end
  end

  // NOTE: clocked state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid1_q <= 1'b0;
      first1_q <= 1'b0;
      last1_q  <= 1'b0;
      prod_q   <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      valid1_q <= valid_i;
      first1_q <= first_i;
      last1_q  <= last_i;
      if (valid_i) prod_q <= prod_d;
      acc_q    <= acc_d;
      done_q   <= valid1_q & last1_q;
    end
  end

  assign acc_o  = acc_q;
  assign done_o = done_q;

endmodule

// File: rtl/dfr_readout.sv
// Readout layer: weights each reservoir node state with a runtime-loadable
// per-node weight, sums one frame of VIRTUAL_NODES products and emits a
// saturated Q(FRAC_BITS) prediction with a one-cycle valid pulse.
// Ports:
//  clk, rst            clock, synchronous active-high reset
//  din_valid, din      reservoir state for the current node
//  sync                with din_valid: this sample is node 0
//  wr_en, wr_addr,
//  wr_data             weight write port (addresses >= VIRTUAL_NODES ignored)
//  dout, dout_valid    frame prediction and its one-cycle strobe
module dfr_readout
  import dfr_pkg::*;
#(
  parameter int VIRTUAL_NODES = 10,
  parameter int DATA_WIDTH    = DFR_DATA_WIDTH,
  parameter int FRAC_BITS     = DFR_FRAC_BITS
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             din_valid,
  input  logic [DATA_WIDTH-1:0]            din,
  input  logic                             sync,
  input  logic                             wr_en,
  input  logic [$clog2(VIRTUAL_NODES)-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0]            wr_data,
  output logic [DATA_WIDTH-1:0]            dout,
  output logic                             dout_valid
);

  localparam int AW    = $clog2(VIRTUAL_NODES);
  localparam int ACC_W = acc_width(DATA_WIDTH, VIRTUAL_NODES);

  typedef logic [AW-1:0] idx_t;
  localparam idx_t LAST_IDX = idx_t'(VIRTUAL_NODES - 1);

  idx_t                   node_idx_q;
  idx_t                   node_idx_d;
  idx_t                   cur_idx;
  logic [DATA_WIDTH-1:0]  weight_q [VIRTUAL_NODES];
  logic [DATA_WIDTH-1:0]  dout_q;
  logic [DATA_WIDTH-1:0]  dout_d;
  logic                   dout_valid_q;
  logic [ACC_W-1:0]       acc;
  logic                   mac_done;

  // A sync sample restarts the frame at node 0; because node 0 reloads the
  // accumulator, any partial frame is dropped without ever reaching "last".
  always_comb begin
    cur_idx    = sync ? '0 : node_idx_q;
    node_idx_d = node_idx_q;
    if (din_valid) begin
      node_idx_d = (cur_idx == LAST_IDX) ? '0 : cur_idx + idx_t'(1);
    end
  end

  dfr_mac #(
    .DW    (DATA_WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (din_valid),
    .first_i  (cur_idx == '0),
    .last_i   (cur_idx == LAST_IDX),
    .din_i    (din),
    .weight_i (weight_q[cur_idx]),
    .acc_o    (acc),
    .done_o   (mac_done)
  );

  assign dout_d = DATA_WIDTH'(saturate(SAT_WIDTH'($signed(acc)), FRAC_BITS, DATA_WIDTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      node_idx_q   <= '0;
      // NOTE: the weight bank is a small register file, not RAM, so it can
      // and must be cleared by reset; a real memory macro could not be.
      for (int i = 0; i < VIRTUAL_NODES; i++) weight_q[i] <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      node_idx_q <= node_idx_d;
      // The stage-1 read above sees the pre-edge weight on a same-cycle write.
      if (wr_en && (int'(wr_addr) < VIRTUAL_NODES)) weight_q[wr_addr] <= wr_data;
      dout_valid_q <= mac_done;
      if (mac_done) dout_q <= dout_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;

endmodule

// File: tb/tb_dfr_readout.sv
// Scoreboard bench for dfr_readout (VN=10, Q16.16). The driver feeds a
// frame-level reference model that pushes expected predictions; a monitor
// on the falling edge pops and compares whenever dout_valid is seen.
module tb_dfr_readout;
  import dfr_pkg::*;

  localparam int VN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        din_valid;
  logic [31:0] din;
  logic        sync;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [31:0] dout;
  logic        dout_valid;

  dfr_readout #(.VIRTUAL_NODES(VN), .DATA_WIDTH(32), .FRAC_BITS(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .sync       (sync),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] val;
    int          edge_no;
  } exp_t;

  exp_t               q[$];
  exp_t               e;
  logic signed [31:0] mw [VN];
  int                 pos;
  logic signed [127:0] sum;
  logic [31:0]        exp_hold;
  bit                 mon_en = 1'b0;

  // Exact frame sum -> floor(sum / 2^16) -> clamp to signed 32-bit.
  function automatic logic [31:0] sat_ref(input logic signed [127:0] s);
    logic signed [127:0] f;
    f = s >>> 16;
    if (f > 128'sd2147483647)  return 32'h7FFF_FFFF;
    if (f < -128'sd2147483648) return 32'h8000_0000;
    return f[31:0];
  endfunction

  task automatic model_sample(input logic [31:0] d, input bit s, input int edge_no);
    exp_t x;
    if (s) pos = 0;
    if (pos == 0) sum = '0;
    sum = sum + $signed(d) * mw[pos];
    if (pos == VN - 1) begin
      x.val     = sat_ref(sum);
      x.edge_no = edge_no + 2;
      q.push_back(x);
    end
    pos = (pos + 1) % VN;
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit v, input logic [31:0] d, input bit s,
                       input bit we, input logic [3:0] wa, input logic [31:0] wd);
    din_valid = v; din = d; sync = s;
    wr_en = we; wr_addr = wa; wr_data = wd;
    @(posedge clk); #1;
    if (v) model_sample(d, s, cyc);       // uses pre-write weights
    if (we && (int'(wa) < VN)) mw[wa] = wd;
    din_valid = 1'b0; sync = 1'b0; wr_en = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic load_all(input logic [31:0] w);
    for (int i = 0; i < VN; i++) drive(1'b0, '0, 1'b0, 1'b1, 4'(i), w);
  endtask

  task automatic frame(input logic [31:0] d, input int max_gap);
    for (int i = 0; i < VN; i++) begin
      drive(1'b1, d, 1'b0, 1'b0, '0, '0);
      if (max_gap > 0) idle($urandom_range(0, max_gap));
    end
  endtask

  task automatic do_reset();
    idle(4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    pos = 0;
    for (int i = 0; i < VN; i++) mw[i] = '0;
    exp_hold = '0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (mon_en) begin
      if (q.size() > 0 && cyc > q[0].edge_no) begin
        e = q.pop_front();
        check("missing_valid", 64'(cyc), 64'(e.edge_no));
      end
      if (dout_valid) begin
        if (q.size() == 0) begin
          check("spurious_valid", 64'(dout_valid), 64'(0));
        end else begin
          e = q.pop_front();
          check("dout", 64'(dout), 64'(e.val));
          check("latency", 64'(cyc), 64'(e.edge_no));
          exp_hold = e.val;
        end
      end else begin
        check("dout_hold", 64'(dout), 64'(exp_hold));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] d, w;
    rst = 1'b1; din_valid = 1'b0; din = '0; sync = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    pos = 0; sum = '0; exp_hold = '0;
    for (int i = 0; i < VN; i++) mw[i] = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_dout", 64'(dout), 64'(0));
    check("rst_valid", 64'(dout_valid), 64'(0));
    mon_en = 1'b1;

    // zero weights after reset
    frame(ONE, 0); idle(4);

    // unit weights: contiguous, gapped, back-to-back
    load_all(ONE);
    frame(ONE, 0); idle(4);
    frame(ONE, 3); idle(4);
    frame(ONE, 0); frame(32'h0002_0000, 0); idle(4);

    // alternating +1/-1 weights, then 0.5 weights
    for (int i = 0; i < VN; i++) drive(1'b0, '0, 1'b0, 1'b1, 4'(i), (i % 2 == 0) ? ONE : NEG_ONE);
    frame(32'h0002_0000, 0); idle(4);
    load_all(32'h0000_8000);
    frame(32'h0003_0000, 1); idle(4);

    // saturation, both directions
    load_all(32'h7FFF_0000);
    frame(32'h7FFF_0000, 0); idle(4);
    load_all(32'h8000_0000);
    frame(32'h7FFF_0000, 0); idle(4);

    // sync abandons a partial frame
    load_all(ONE);
    for (int i = 0; i < 4; i++) drive(1'b1, ONE, 1'b0, 1'b0, '0, '0);
    drive(1'b1, ONE, 1'b1, 1'b0, '0, '0);
    for (int i = 1; i < VN; i++) drive(1'b1, ONE, 1'b0, 1'b0, '0, '0);
    idle(2);
    drive(1'b0, '0, 1'b1, 1'b0, '0, '0);   // sync without din_valid ignored
    frame(ONE, 0); idle(4);

    // reset mid-frame discards it
    for (int i = 0; i < 5; i++) drive(1'b1, ONE, 1'b0, 1'b0, '0, '0);
    do_reset();
    load_all(ONE);
    frame(ONE, 0); idle(4);

    // same-cycle weight write uses the old weight; out-of-range write ignored
    load_all('0);
    drive(1'b0, '0, 1'b0, 1'b1, 4'd0, ONE);
    drive(1'b1, ONE, 1'b0, 1'b1, 4'd0, 32'h0002_0000);
    for (int i = 1; i < VN; i++) drive(1'b1, ONE, 1'b0, 1'b0, '0, '0);
    idle(3);
    frame(ONE, 0); idle(3);
    drive(1'b0, '0, 1'b0, 1'b1, 4'd12, 32'h1234_5678);
    frame(ONE, 0); idle(4);

    // randomized traffic: writes, gaps, occasional sync, wide data
    for (int n = 0; n < 600; n++) begin
      d = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 32'h0008_0000)) - 32'h0004_0000;
      w = ($urandom_range(0, 7) == 0) ? $urandom() : 32'($urandom_range(0, 32'h0004_0000)) - 32'h0002_0000;
      drive(1'($urandom_range(0, 3) != 0), d, 1'($urandom_range(0, 39) == 0),
            1'($urandom_range(0, 5) == 0), 4'($urandom_range(0, 15)), w);
    end
    idle(6);

    check("drain", 64'(q.size()), 64'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
